uart_io_controller: RTL and testbench
=====================================

# uart_io_controller

Memory-mapped controller that sits between the CPU's memory stage and the `UART` block. It decodes the IO address window, buffers outgoing bytes in a TX FIFO, and sequences the UART `DataIn` valid/ready handshake with a small FSM. It also drains received bytes into an RX FIFO, so CPU loads and stores never have to meet UART handshake timing directly.

## Interface
Parameters:
- `FIFO_DEPTH`, 4: entries per FIFO; power of two, at least 2.
- `PTR_WIDTH`, 2: log2(`FIFO_DEPTH`).

Ports:
- `Clock` in 1: single clock; all state updates on its rising edge.
- `Reset` in 1: asynchronous, active-high; clears all state.
- `Addr` in 32: CPU byte address for the current access.
- `WriteData` in 32: store data; only [7:0] is used.
- `IOWrite` in 1: store strobe; one cycle per store.
- `IORead` in 1: load strobe; one cycle per load.
- `ReadData` out 32: load data; combinational from `Addr` and current state.
- `UartDataIn` out 8: byte presented to the UART transmitter.
- `UartDataInValid` out 1: TX handshake valid.
- `UartDataInReady` in 1: TX handshake ready from the UART.
- `UartDataOut` in 8: byte from the UART receiver.
- `UartDataOutValid` in 1: RX handshake valid from the UART.
- `UartDataOutReady` out 1: RX handshake ready.

## Operation
Decoding uses an exact 32-bit match; all other addresses are ignored. Reads from unmapped or write-only addresses return 0. `IORead` and `IOWrite` are decoded independently.

Register map:
- 0x80000000, read-only status, `{28'b0, tx_ovf, rx_udf, rx_nonempty, tx_notfull}`.
- 0x80000004, read: returns `{24'b0, rx_head}` and pops the RX FIFO on the edge.
  - If the RX FIFO is empty, returns 0, pops nothing, and sets sticky `rx_udf`.
- 0x80000008, write: pushes `WriteData[7:0]` into the TX FIFO.
  - If the TX FIFO is full before the edge, the byte is dropped and sticky `tx_ovf` is set. A push is never accepted on the strength of a same-edge pop.
- 0x8000000C, write: clears `tx_ovf` and `rx_udf`. The data value is ignored.
- If a clear and a new error event occur on the same edge, the set wins.

TX FIFO and FSM:
- States: IDLE, SEND.
- IDLE -> SEND when the TX FIFO is non-empty. On that edge the head byte is copied into the `UartDataIn` holding register and popped.
- In SEND, `UartDataInValid`=1 and `UartDataIn` holds the byte steady.
- SEND -> IDLE on the edge where `UartDataInReady`=1.
- `UartDataInValid` is a registered output, high only in SEND.
- The holding register frees a FIFO slot as soon as SEND is entered, so capacity is `FIFO_DEPTH`+1 bytes in flight.

RX path:
- `UartDataOutReady` = !rx_full (combinational).
- A byte is pushed on every edge where `UartDataOutValid` and `UartDataOutReady` are both high.
- A push and a CPU pop on the same edge are both performed: the count is unchanged and the data stays correctly ordered, including when the FIFO starts empty (the empty pop returns 0 and sets `rx_udf`; the push lands) and when it starts full (no push occurs, because ready is low).

FIFO mechanics:
- Read/write pointers are `PTR_WIDTH` bits and wrap modulo `FIFO_DEPTH`.
- Each FIFO has an occupancy counter of `PTR_WIDTH`+1 bits.
- full = (count == `FIFO_DEPTH`); empty = (count == 0).

## Timing
Reset values:
- `UartDataInValid`=0, `UartDataIn`=0, FSM=IDLE.
- Both FIFOs empty, all pointers 0, `tx_ovf`=`rx_udf`=0.
- `UartDataOutReady`=1.
- `ReadData` at 0x80000000 = 0x00000001.

TX timing:
- Store accepted at edge k.
- FSM enters SEND at edge k+1; `UartDataInValid` is high from k+1.
- With ready held high, the transfer completes at edge k+2, giving a back-to-back throughput of 1 byte per 2 cycles.

RX timing:
- Byte pushed at edge k; status bit1 = 1 and the byte is readable from cycle k+1.

Reset mid-operation:
- Asserting `Reset` in SEND drops `UartDataInValid` asynchronously.
- Any buffered bytes are discarded.

## Test plan
- Reset, then read 0x80000000 -> 0x00000001; `UartDataInValid`=0; `UartDataOutReady`=1.
- Store 0x41, 0x42, 0x43 to 0x80000008 with `UartDataInReady`=1 -> `UartDataIn` shows 0x41, 0x42, 0x43 in order, each valid for exactly one cycle, valid pulses 2 cycles apart.
- Hold `UartDataInReady`=0 and store 6 bytes with `FIFO_DEPTH`=4 -> the first 5 are held (1 in SEND plus 4 in the FIFO), the 6th is dropped, status = 0x8 (`tx_ovf`=1, `tx_notfull`=0); a store to 0x8000000C then clears bit3.
- Drive 4 RX bytes 0x10..0x13 -> `UartDataOutReady` falls after the 4th; loads from 0x80000004 return 0x10..0x13 in order; a 5th load returns 0 and sets status bit2.
- RX FIFO holds 1 byte; an RX push and a CPU pop occur on the same edge -> the load returns the old byte, the count stays 1, and the next load returns the new byte.
- Assert `Reset` while in SEND with 2 bytes queued -> `UartDataInValid` drops immediately and status = 0x1 after release.

Source files
------------

// File: rtl/uart_io_controller_if.sv
// CPU-side IO bus and UART byte handshakes used by uart_io_controller.
// The master modport is the CPU/UART side; the slave modport is the controller.
interface uart_io_controller_if;
  // CPU memory-stage bus
  logic [31:0] Addr;
  logic [31:0] WriteData;
  logic        IOWrite;
  logic        IORead;
  logic [31:0] ReadData;

  // UART transmitter handshake (controller -> UART)
  logic [7:0]  UartDataIn;
  logic        UartDataInValid;
  logic        UartDataInReady;

  // UART receiver handshake (UART -> controller)
  logic [7:0]  UartDataOut;
  logic        UartDataOutValid;
  logic        UartDataOutReady;

  modport master (
    output Addr, WriteData, IOWrite, IORead,
    input  ReadData,
    input  UartDataIn, UartDataInValid,
    output UartDataInReady,
    output UartDataOut, UartDataOutValid,
    input  UartDataOutReady
  );

  modport slave (
    input  Addr, WriteData, IOWrite, IORead,
    output ReadData,
    output UartDataIn, UartDataInValid,
    input  UartDataInReady,
    input  UartDataOut, UartDataOutValid,
    output UartDataOutReady
  );
endinterface

// File: rtl/uart_io_controller.sv
// Memory-mapped UART controller: decodes the IO window, buffers TX bytes in a
// FIFO drained by a two-state send FSM, and buffers RX bytes for CPU loads.
module uart_io_controller #(
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_WIDTH  = 2
) (
  input  logic               Clock,
  input  logic               Reset,
  uart_io_controller_if.slave bus
);

  localparam logic [31:0] ADDR_STATUS = 32'h8000_0000;
  localparam logic [31:0] ADDR_RXDATA = 32'h8000_0004;
  localparam logic [31:0] ADDR_TXDATA = 32'h8000_0008;
  localparam logic [31:0] ADDR_CLEAR  = 32'h8000_000C;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  localparam logic [PTR_WIDTH:0]   FULL_COUNT = (PTR_WIDTH + 1)'(FIFO_DEPTH);
  localparam logic [PTR_WIDTH:0]   COUNT_ONE  = (PTR_WIDTH + 1)'(1);
  localparam logic [PTR_WIDTH-1:0] PTR_ONE    = PTR_WIDTH'(1);

  // TX FIFO state
  logic [7:0]           tx_mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
  logic [PTR_WIDTH-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
  logic [PTR_WIDTH:0]   tx_count_q, tx_count_d;

  // RX FIFO state
  logic [7:0]           rx_mem_q [FIFO_DEPTH];
  logic [PTR_WIDTH-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
  logic [PTR_WIDTH-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
  logic [PTR_WIDTH:0]   rx_count_q, rx_count_d;

  // Send FSM and its holding register
  logic [0:0] state_q, state_d;
  logic       in_valid_q, in_valid_d;
  logic [7:0] in_data_q, in_data_d;

  // Sticky error flags
  logic tx_ovf_q, tx_ovf_d;
  logic rx_udf_q, rx_udf_d;

  // Decode and handshake qualifiers
  logic sel_status, sel_rxdata, sel_txdata, sel_clear;
  logic tx_full, tx_empty, rx_full, rx_empty;
  logic tx_push_req, tx_push, tx_ovf_evt, tx_pop;
  logic rx_pop_req, rx_pop, rx_udf_evt, rx_push;
  logic flag_clear;
  logic [7:0] rx_head;

  // Upper store-data bits carry no meaning for this block.
  logic unused_wdata_bits;
  assign unused_wdata_bits = ^bus.WriteData[31:8];

  assign tx_full  = (tx_count_q == FULL_COUNT);
  assign tx_empty = (tx_count_q == '0);
  assign rx_full  = (rx_count_q == FULL_COUNT);
  assign rx_empty = (rx_count_q == '0);
  assign rx_head  = rx_mem_q[rx_rd_ptr_q];

  // Exact-match address decode and per-access event qualification.
  always_comb begin
    sel_status  = (bus.Addr == ADDR_STATUS);
    sel_rxdata  = (bus.Addr == ADDR_RXDATA);
    sel_txdata  = (bus.Addr == ADDR_TXDATA);
    sel_clear   = (bus.Addr == ADDR_CLEAR);

    tx_push_req = bus.IOWrite && sel_txdata;
    tx_push     = tx_push_req && !tx_full;
    tx_ovf_evt  = tx_push_req && tx_full;

    rx_pop_req  = bus.IORead && sel_rxdata;
    rx_pop      = rx_pop_req && !rx_empty;
    rx_udf_evt  = rx_pop_req && rx_empty;

    rx_push     = bus.UartDataOutValid && !rx_full;
    flag_clear  = bus.IOWrite && sel_clear;
  end

  // Send FSM: grab the TX head into the holding register, then wait for ready.
  always_comb begin
    state_d    = state_q;
    in_valid_d = in_valid_q;
    in_data_d  = in_data_q;
    tx_pop     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!tx_empty) begin
          state_d    = ST_SEND;
          in_valid_d = 1'b1;
          in_data_d  = tx_mem_q[tx_rd_ptr_q];
          tx_pop     = 1'b1;
        end
      end
      ST_SEND: begin
        if (bus.UartDataInReady) begin
          state_d    = ST_IDLE;
          in_valid_d = 1'b0;
        end
      end
      default: begin
        state_d    = ST_IDLE;
        in_valid_d = 1'b0;
      end
    endcase
  end

  // FIFO pointer and occupancy updates; a simultaneous push and pop leave the count unchanged.
  always_comb begin
    tx_wr_ptr_d = tx_push ? tx_wr_ptr_q + PTR_ONE : tx_wr_ptr_q;
    tx_rd_ptr_d = tx_pop  ? tx_rd_ptr_q + PTR_ONE : tx_rd_ptr_q;
    tx_count_d  = tx_count_q;
    if (tx_push && !tx_pop) tx_count_d = tx_count_q + COUNT_ONE;
    if (!tx_push && tx_pop) tx_count_d = tx_count_q - COUNT_ONE;

    rx_wr_ptr_d = rx_push ? rx_wr_ptr_q + PTR_ONE : rx_wr_ptr_q;
    rx_rd_ptr_d = rx_pop  ? rx_rd_ptr_q + PTR_ONE : rx_rd_ptr_q;
    rx_count_d  = rx_count_q;
    if (rx_push && !rx_pop) rx_count_d = rx_count_q + COUNT_ONE;
    if (!rx_push && rx_pop) rx_count_d = rx_count_q - COUNT_ONE;
  end

  // Sticky error flags: clear first so that a same-edge error event wins.
  always_comb begin
    tx_ovf_d = tx_ovf_q;
    rx_udf_d = rx_udf_q;
    if (flag_clear) begin
      tx_ovf_d = 1'b0;
      rx_udf_d = 1'b0;
    end
    if (tx_ovf_evt) tx_ovf_d = 1'b1;
    if (rx_udf_evt) rx_udf_d = 1'b1;
  end

  // Load data mux; unmapped and write-only addresses read as zero.
  always_comb begin
    bus.ReadData = 32'h0;
    if (sel_status) begin
      bus.ReadData = {28'h0, tx_ovf_q, rx_udf_q, !rx_empty, !tx_full};
    end else if (sel_rxdata && !rx_empty) begin
      bus.ReadData = {24'h0, rx_head};
    end
  end

  assign bus.UartDataIn       = in_data_q;
  assign bus.UartDataInValid  = in_valid_q;
  assign bus.UartDataOutReady = !rx_full;

  // Control state registers.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tx_wr_ptr_q <= '0;
      tx_rd_ptr_q <= '0;
      tx_count_q  <= '0;
      rx_wr_ptr_q <= '0;
      rx_rd_ptr_q <= '0;
      rx_count_q  <= '0;
      state_q     <= ST_IDLE;
      in_valid_q  <= 1'b0;
      in_data_q   <= 8'h0;
      tx_ovf_q    <= 1'b0;
      rx_udf_q    <= 1'b0;
    end else begin
      tx_wr_ptr_q <= tx_wr_ptr_d;
      tx_rd_ptr_q <= tx_rd_ptr_d;
      tx_count_q  <= tx_count_d;
      rx_wr_ptr_q <= rx_wr_ptr_d;
      rx_rd_ptr_q <= rx_rd_ptr_d;
      rx_count_q  <= rx_count_d;
      state_q     <= state_d;
      in_valid_q  <= in_valid_d;
      in_data_q   <= in_data_d;
      tx_ovf_q    <= tx_ovf_d;
      rx_udf_q    <= rx_udf_d;
    end
  end

  // FIFO storage: write the tail slot of each FIFO on an accepted push.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tx_mem_q[i] <= 8'h0;
        rx_mem_q[i] <= 8'h0;
      end
    end else begin
      if (tx_push) tx_mem_q[tx_wr_ptr_q] <= bus.WriteData[7:0];
      if (rx_push) rx_mem_q[rx_wr_ptr_q] <= bus.UartDataOut;
    end
  end

endmodule

// File: tb/tb_uart_io_controller.sv
// Self-checking bench for uart_io_controller: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_uart_io_controller;

  localparam int DEPTH = 4;
  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RX     = 32'h8000_0004;
  localparam logic [31:0] A_TX     = 32'h8000_0008;
  localparam logic [31:0] A_CLR    = 32'h8000_000C;

  logic Clock = 1'b0;
  logic Reset;
  int checkCount = 0;
  int errorCount = 0;

  // Reference model: byte queues plus the byte currently offered to the UART.
  logic [7:0] txQ[$];
  logic [7:0] rxQ[$];
  logic       txBusy;
  logic [7:0] txHold;
  logic       txOvf;
  logic       rxUdf;

  uart_io_controller_if bus();

  uart_io_controller #(.FIFO_DEPTH(DEPTH), .PTR_WIDTH(2)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .bus(bus.slave)
  );

  // Free-running 100 MHz clock.
  always #5 Clock = ~Clock;

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", tag, actual, expected);
    end
  endtask

  // What a load from addr should return given the model's current contents.
  function automatic logic [31:0] modelReadData(input logic [31:0] addr);
    logic [31:0] r;
    r = 32'h0;
    if (addr == A_STATUS)
      r = {28'h0, txOvf, rxUdf, rxQ.size() != 0, txQ.size() < DEPTH};
    else if (addr == A_RX && rxQ.size() != 0)
      r = {24'h0, rxQ[0]};
    return r;
  endfunction

  // Empties the model, matching the effect of Reset.
  task automatic modelReset();
    txQ.delete();
    rxQ.delete();
    txBusy = 1'b0;
    txHold = 8'h0;
    txOvf  = 1'b0;
    rxUdf  = 1'b0;
  endtask

  // Advances the model by one clock edge; all decisions use pre-edge occupancy.
  task automatic modelStep(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                           input logic rd, input logic inReady, input logic [7:0] outByte,
                           input logic outValid);
    int txPre;
    int rxPre;
    txPre = txQ.size();
    rxPre = rxQ.size();
    if (wr && addr == A_CLR) begin
      txOvf = 1'b0;
      rxUdf = 1'b0;
    end
    if (rd && addr == A_RX) begin
      if (rxPre > 0) void'(rxQ.pop_front());
      else rxUdf = 1'b1;
    end
    if (outValid && rxPre < DEPTH) rxQ.push_back(outByte);
    if (txBusy) begin
      if (inReady) txBusy = 1'b0;
    end else if (txPre > 0) begin
      txHold = txQ.pop_front();
      txBusy = 1'b1;
    end
    if (wr && addr == A_TX) begin
      if (txPre < DEPTH) txQ.push_back(wdata[7:0]);
      else txOvf = 1'b1;
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, check outputs, then step the model.
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata, input logic wr,
                               input logic rd, input logic inReady, input logic [7:0] outByte,
                               input logic outValid);
    @(negedge Clock);
    bus.Addr             = addr;
    bus.WriteData        = wdata;
    bus.IOWrite          = wr;
    bus.IORead           = rd;
    bus.UartDataInReady  = inReady;
    bus.UartDataOut      = outByte;
    bus.UartDataOutValid = outValid;
    #1;
    checkOutput("ReadData", bus.ReadData, modelReadData(addr));
    checkOutput("InValid", {31'h0, bus.UartDataInValid}, {31'h0, txBusy});
    checkOutput("InData", {24'h0, bus.UartDataIn}, {24'h0, txHold});
    checkOutput("OutReady", {31'h0, bus.UartDataOutReady}, {31'h0, rxQ.size() < DEPTH});
    modelStep(addr, wdata, wr, rd, inReady, outByte, outValid);
  endtask

  // Directed scenarios followed by random traffic.
  initial begin
    logic [31:0] addrTable [6];
    addrTable[0] = A_STATUS;
    addrTable[1] = A_RX;
    addrTable[2] = A_TX;
    addrTable[3] = A_CLR;
    addrTable[4] = 32'h8000_0010;
    addrTable[5] = 32'h0000_0008;

    modelReset();
    Reset                = 1'b1;
    bus.Addr             = A_STATUS;
    bus.WriteData        = 32'h0;
    bus.IOWrite          = 1'b0;
    bus.IORead           = 1'b0;
    bus.UartDataInReady  = 1'b0;
    bus.UartDataOut      = 8'h0;
    bus.UartDataOutValid = 1'b0;

    // Reset state.
    #12;
    checkOutput("RstStatus", bus.ReadData, 32'h1);
    checkOutput("RstInValid", {31'h0, bus.UartDataInValid}, 32'h0);
    checkOutput("RstOutReady", {31'h0, bus.UartDataOutReady}, 32'h1);
    @(negedge Clock);
    Reset = 1'b0;

    // Three back-to-back stores with the UART always ready.
    $display("[TB] tx ordering");
    for (int i = 0; i < 3; i++) applyStimulus(A_TX, 32'h41 + i, 1, 0, 1, 8'h0, 0);
    for (int i = 0; i < 6; i++) applyStimulus(A_STATUS, 0, 0, 0, 1, 8'h0, 0);

    // Overflow with the UART stalled: five bytes held, the sixth dropped.
    $display("[TB] tx overflow");
    for (int i = 0; i < 6; i++) applyStimulus(A_TX, 32'hA50 + i, 1, 0, 0, 8'h0, 0);
    applyStimulus(A_STATUS, 0, 0, 0, 0, 8'h0, 0);
    checkOutput("OvfStatus", bus.ReadData, 32'h8);
    applyStimulus(A_CLR, 32'hFFFF_FFFF, 1, 0, 0, 8'h0, 0);
    applyStimulus(A_STATUS, 0, 0, 0, 0, 8'h0, 0);
    checkOutput("OvfCleared", bus.ReadData, 32'h0);
    for (int i = 0; i < 12; i++) applyStimulus(A_STATUS, 0, 0, 0, 1, 8'h0, 0);

    // Fill the RX FIFO, then drain it with one load too many.
    $display("[TB] rx fill and drain");
    for (int i = 0; i < 4; i++) applyStimulus(A_STATUS, 0, 0, 0, 1, 8'h10 + 8'(i), 1);
    applyStimulus(A_STATUS, 0, 0, 0, 1, 8'h0, 0);
    checkOutput("RxFullReady", {31'h0, bus.UartDataOutReady}, 32'h0);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(A_RX, 0, 0, 1, 1, 8'h0, 0);
      checkOutput("RxLoad", bus.ReadData, (i < 4) ? 32'h10 + i : 32'h0);
    end
    applyStimulus(A_STATUS, 0, 0, 0, 1, 8'h0, 0);
    checkOutput("UdfStatus", bus.ReadData, 32'h5);

    // Same-edge RX push and CPU pop with one byte already buffered.
    $display("[TB] rx push and pop together");
    applyStimulus(A_CLR, 0, 1, 0, 1, 8'h0, 0);
    applyStimulus(A_STATUS, 0, 0, 0, 1, 8'h20, 1);
    applyStimulus(A_RX, 0, 0, 1, 1, 8'h21, 1);
    checkOutput("SameEdgeOld", bus.ReadData, 32'h20);
    applyStimulus(A_RX, 0, 0, 1, 1, 8'h0, 0);
    checkOutput("SameEdgeNew", bus.ReadData, 32'h21);
    applyStimulus(A_STATUS, 0, 0, 0, 1, 8'h0, 0);
    checkOutput("SameEdgeStatus", bus.ReadData, 32'h1);

    // Random traffic across all addresses, handshakes and strobes.
    $display("[TB] random traffic");
    for (int i = 0; i < 600; i++) begin
      applyStimulus(addrTable[$urandom_range(0, 5)], $urandom,
                    $urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                    $urandom_range(0, 3) == 0, 8'($urandom), $urandom_range(0, 1) == 1);
    end

    // Reset asserted while a byte is being offered and two more are queued.
    $display("[TB] reset during send");
    for (int i = 0; i < 8; i++) applyStimulus(A_STATUS, 0, 0, 0, 1, 8'h0, 0);
    for (int i = 0; i < 3; i++) applyStimulus(A_TX, 32'h60 + i, 1, 0, 0, 8'h0, 0);
    applyStimulus(A_STATUS, 0, 0, 0, 0, 8'h0, 0);
    checkOutput("PreRstValid", {31'h0, bus.UartDataInValid}, 32'h1);
    bus.IOWrite = 1'b0;
    bus.IORead  = 1'b0;
    #1;
    Reset = 1'b1;
    #1;
    checkOutput("AsyncRstValid", {31'h0, bus.UartDataInValid}, 32'h0);
    modelReset();
    @(negedge Clock);
    Reset = 1'b0;
    applyStimulus(A_STATUS, 0, 0, 0, 0, 8'h0, 0);
    checkOutput("PostRstStatus", bus.ReadData, 32'h1);
    applyStimulus(A_STATUS, 0, 0, 0, 1, 8'h0, 0);
    checkOutput("PostRstValid", {31'h0, bus.UartDataInValid}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
